// File: rtl/instr_queue_if.sv
// Fetcher/decoder/backend-facing signal bundle of the instruction queue.
// The queue takes the slave modport; the surrounding pipeline drives the master side.
interface instr_queue_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               push_from_fetcher;
  logic [PC_W-1:0]    pc_from_fetcher;
  logic [INSTR_W-1:0] instr_from_fetcher;
  logic               is_full_to_fetcher;
  logic               stall_from_backend;
  logic               is_empty_to_dc;
  logic [PC_W-1:0]    pc_to_dc;
  logic [INSTR_W-1:0] instr_to_dc;

  modport master (
    output push_from_fetcher, pc_from_fetcher, instr_from_fetcher, stall_from_backend,
    input  is_full_to_fetcher, is_empty_to_dc, pc_to_dc, instr_to_dc
  );

  modport slave (
    input  push_from_fetcher, pc_from_fetcher, instr_from_fetcher, stall_from_backend,
    output is_full_to_fetcher, is_empty_to_dc, pc_to_dc, instr_to_dc
  );
endinterface

// File: rtl/instr_queue.sv
// Circular first-word-fall-through buffer of (pc, instruction) pairs between
// the fetcher and the decoder; flushed on redirect, frozen while rdy is low.
module instr_queue #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clr,
  instr_queue_if.slave q
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;
  logic advance;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Fullness is judged on the start-of-cycle count, so a pop never makes room
  // for a same-cycle push.
  assign push_ok = q.push_from_fetcher && !full;
  assign pop_ok  = !empty && !q.stall_from_backend;
  assign advance = !rst && rdy && !clr;

  assign q.is_empty_to_dc     = empty;
  assign q.is_full_to_fetcher = full;
  assign q.pc_to_dc           = empty ? '0 : pc_mem[head];
  assign q.instr_to_dc        = empty ? '0 : instr_mem[head];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (advance && push_ok) begin
      pc_mem[tail]    <= q.pc_from_fetcher;
      instr_mem[tail] <= q.instr_from_fetcher;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (clr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_ok) tail <= tail + 1'b1;
        if (pop_ok)  head <= head + 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
